// File: rtl/stepper_motor_step_dir_gen_pkg.sv
// Shared FSM encoding and width derivations for the stepper STEP/DIR output stage.
package stepper_motor_step_dir_gen_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDirSetup = 2'd1,
    StHigh     = 2'd2,
    StLow      = 2'd3
  } step_state_e;

  // Integer position bits plus the driver's microstep fraction bits.
  function automatic int unsigned count_width(input int unsigned x_width,
                                              input int unsigned q_width,
                                              input int unsigned microstep_shift);
    return x_width - q_width + microstep_shift;
  endfunction

  function automatic int unsigned target_shift(input int unsigned q_width,
                                               input int unsigned microstep_shift);
    return q_width - microstep_shift;
  endfunction

endpackage

// File: rtl/stepper_motor_step_pulse_timer.sv
// Loadable down-counter; a load of N gives N cycles until done, with 0 treated as 1.
module stepper_motor_step_pulse_timer #(
  parameter int unsigned TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] cycles,
  output logic                   done
);

  logic [TIMER_WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= (cycles == '0) ? '0 : cycles - TIMER_WIDTH'(1);
    end else if (count_q != '0) begin
      count_q <= count_q - TIMER_WIDTH'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/stepper_motor_step_dir_gen.sv
// Converts fixed-point position updates into timed STEP/DIR pulses for a microstepping driver.
module stepper_motor_step_dir_gen
  import stepper_motor_step_dir_gen_pkg::*;
#(
  parameter int unsigned X_WIDTH          = 48,
  parameter int unsigned Q_WIDTH          = 24,
  parameter int unsigned MICROSTEP_SHIFT  = 4,
  parameter int unsigned COUNT_WIDTH      = count_width(X_WIDTH, Q_WIDTH, MICROSTEP_SHIFT),
  parameter int unsigned TIMER_WIDTH      = 16,
  parameter int unsigned DIR_SETUP_CYCLES = 4,
  parameter int unsigned STEP_HIGH_CYCLES = 3,
  parameter int unsigned STEP_LOW_CYCLES  = 5,
  parameter int unsigned MAX_LAG          = 8,
  parameter bit          DIR_INVERT       = 1'b0
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic                          enable,
  input  logic signed [X_WIDTH-1:0]     in_x,
  input  logic                          in_valid,
  input  logic                          preset,
  input  logic signed [X_WIDTH-1:0]     preset_x,
  input  logic                          clear_err,
  output logic                          step_out,
  output logic                          dir_out,
  output logic                          busy,
  output logic signed [COUNT_WIDTH-1:0] cur_step,
  output logic signed [COUNT_WIDTH-1:0] lag,
  output logic                          err_lag
);

  localparam int unsigned Shift = target_shift(Q_WIDTH, MICROSTEP_SHIFT);
  localparam logic [TIMER_WIDTH-1:0] DirSetupCycles = TIMER_WIDTH'(DIR_SETUP_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] HighCycles     = TIMER_WIDTH'(STEP_HIGH_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] LowCycles      = TIMER_WIDTH'(STEP_LOW_CYCLES);
  localparam logic signed [COUNT_WIDTH-1:0] MaxLag  = COUNT_WIDTH'(MAX_LAG);
  localparam logic signed [COUNT_WIDTH-1:0] One     = COUNT_WIDTH'(1);

  step_state_e                   state_q;
  logic                          step_q;
  logic                          dir_q;
  logic                          err_q;
  logic signed [COUNT_WIDTH-1:0] cur_step_q;
  logic signed [COUNT_WIDTH-1:0] target_q;
  logic signed [COUNT_WIDTH-1:0] in_conv;
  logic signed [COUNT_WIDTH-1:0] preset_conv;
  logic                          want;
  logic                          lag_over;
  logic                          tmr_load;
  logic [TIMER_WIDTH-1:0]        tmr_cycles;
  logic                          tmr_done;

  // Arithmetic shift floors toward -inf; truncation keeps the counter modulo 2^COUNT_WIDTH.
  assign in_conv     = COUNT_WIDTH'(in_x >>> Shift);
  assign preset_conv = COUNT_WIDTH'(preset_x >>> Shift);

  assign lag      = target_q - cur_step_q;
  assign want     = ~lag[COUNT_WIDTH-1];
  assign lag_over = (lag > MaxLag) || (lag < -MaxLag);

  always_comb begin
    tmr_load   = 1'b0;
    tmr_cycles = '0;
    if (!preset) begin
      unique case (state_q)
        StIdle: begin
          if (enable && lag != '0) begin
            tmr_load   = 1'b1;
            tmr_cycles = (want != dir_q) ? DirSetupCycles : HighCycles;
          end
        end
        StDirSetup: begin
          tmr_load   = tmr_done;
          tmr_cycles = HighCycles;
        end
        StHigh: begin
          tmr_load   = tmr_done;
          tmr_cycles = LowCycles;
        end
        default: ;
      endcase
    end
  end

  stepper_motor_step_pulse_timer #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .cycles (tmr_cycles),
    .done   (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      cur_step_q <= '0;
      target_q   <= '0;
    end else if (preset) begin
      state_q    <= StIdle;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      cur_step_q <= preset_conv;
      target_q   <= preset_conv;
    end else begin
      if (in_valid) target_q <= in_conv;
      err_q <= lag_over | (err_q & ~clear_err);
      unique case (state_q)
        StIdle: begin
          if (enable && lag != '0) begin
            if (want != dir_q) begin
              dir_q   <= want;
              state_q <= StDirSetup;
            end else begin
              step_q  <= 1'b1;
              state_q <= StHigh;
            end
          end
        end
        StDirSetup: begin
          if (tmr_done) begin
            step_q  <= 1'b1;
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (tmr_done) begin
            step_q     <= 1'b0;
            cur_step_q <= dir_q ? cur_step_q + One : cur_step_q - One;
            state_q    <= StLow;
          end
        end
        StLow: begin
          if (tmr_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign step_out = step_q;
  assign dir_out  = dir_q ^ DIR_INVERT;
  assign busy     = (state_q != StIdle);
  assign cur_step = cur_step_q;
  assign err_lag  = err_q;

endmodule

// File: tb/tb_stepper_motor_step_dir_gen.sv
// Bench: directed scenarios plus random moves, checked by a pin-level model of a driver IC.
module tb_stepper_motor_step_dir_gen;

  localparam int CW = 28;
  localparam bit DirInvert = 1'b0;

  logic                 clk = 1'b0;
  logic                 reset, enable, in_valid, preset, clear_err;
  logic signed [47:0]   in_x, preset_x;
  logic                 step_out, dir_out, busy, err_lag;
  logic signed [CW-1:0] cur_step, lag;

  int     n_checks = 0;
  int     n_fail = 0;
  bit     mon_en = 1'b0;
  bit     pre_skip = 1'b0;
  longint model_pos = 0;
  longint model_target = 0;
  bit     model_err = 1'b0;
  int     rise_cnt = 0;
  int     setup_q[$];
  int     low_q[$];
  longint fall_q[$];

  stepper_motor_step_dir_gen #(.DIR_INVERT(DirInvert)) dut (
    .reset     (reset),
    .clk       (clk),
    .enable    (enable),
    .in_x      (in_x),
    .in_valid  (in_valid),
    .preset    (preset),
    .preset_x  (preset_x),
    .clear_err (clear_err),
    .step_out  (step_out),
    .dir_out   (dir_out),
    .busy      (busy),
    .cur_step  (cur_step),
    .lag       (lag),
    .err_lag   (err_lag)
  );

  initial forever #5 clk = ~clk;

  // Floor of x / 2^20: one driver microstep per 2^20 of position.
  function automatic longint to_usteps(input longint x);
    longint unit;
    longint q;
    unit = longint'(1) << 20;
    q = x / unit;
    if (x < 0 && (x % unit) != 0) q = q - 1;
    return q;
  endfunction

  // Commanded target, follow-error flag and preset as seen at each clock edge.
  initial forever begin
    @(posedge clk);
    if (mon_en) begin
      if (preset) begin
        model_err    = 1'b0;
        model_target = to_usteps(longint'(preset_x));
        model_pos    = model_target;
        pre_skip     = 1'b1;
      end else begin
        model_err = ((model_target - model_pos) > 8) || ((model_target - model_pos) < -8) ||
                    (model_err && !clear_err);
        if (in_valid) model_target = to_usteps(longint'(in_x));
      end
    end
  end

  // Pin monitor: counts STEP falls signed by DIR and checks pulse timing every cycle.
  initial begin
    bit prev_step, prev_dir, seen_fall;
    int high_cnt, low_cnt, dir_cnt;
    prev_step = 0; prev_dir = 0; seen_fall = 0; high_cnt = 0; low_cnt = 0; dir_cnt = 100;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_step = 0; prev_dir = dir_out; seen_fall = 0; high_cnt = 0; low_cnt = 0;
        dir_cnt = 100; pre_skip = 0;
      end else begin
        if (pre_skip) begin
          pre_skip = 0; seen_fall = 0; high_cnt = 0; low_cnt = 0;
        end else if (step_out && !prev_step) begin
          rise_cnt++;
          setup_q.push_back(dir_cnt);
          low_q.push_back(seen_fall ? low_cnt : -1);
          n_checks++;
          if (dir_cnt < 4) begin
            n_fail++; $display("FAIL dir_setup: %0d cycles, need >= 4", dir_cnt);
          end
          if (seen_fall) begin
            n_checks++;
            if (low_cnt < 5) begin
              n_fail++; $display("FAIL step_low: %0d cycles, need >= 5", low_cnt);
            end
          end
          high_cnt = 1;
        end else if (step_out) begin
          high_cnt++;
        end else if (prev_step) begin
          n_checks++;
          if (high_cnt != 3) begin
            n_fail++; $display("FAIL step_high: %0d cycles, need 3", high_cnt);
          end
          model_pos = model_pos + (((dir_out ^ DirInvert) == 1'b1) ? 1 : -1);
          fall_q.push_back(model_pos);
          seen_fall = 1; low_cnt = 1;
        end else begin
          low_cnt++;
        end
        if (dir_out != prev_dir) begin
          n_checks++;
          if (step_out) begin
            n_fail++; $display("FAIL dir_during_high: dir=%0b step=%0b, need step 0", dir_out, step_out);
          end
          dir_cnt = 1;
        end else begin
          dir_cnt++;
        end
        n_checks++;
        if (longint'(cur_step) != model_pos) begin
          n_fail++; $display("FAIL cur_step: got %0d expected %0d", cur_step, model_pos);
        end
        n_checks++;
        if (longint'(lag) != model_target - model_pos) begin
          n_fail++; $display("FAIL lag: got %0d expected %0d", lag, model_target - model_pos);
        end
        n_checks++;
        if (err_lag !== model_err) begin
          n_fail++; $display("FAIL err_lag: got %0b expected %0b", err_lag, model_err);
        end
        prev_step = step_out; prev_dir = dir_out;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input longint x);
    in_x = 48'(x); in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic settle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && lag == 0) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic clear_hist();
    setup_q.delete(); low_q.delete(); fall_q.delete();
  endtask

  task automatic test_reset_init();
    reset = 1; enable = 0; in_valid = 0; preset = 0; clear_err = 0; in_x = 0; preset_x = 0;
    #1;
    n_checks++; if (step_out !== 1'b0) begin n_fail++; $display("FAIL init_step: got %0b expected 0", step_out); end
    n_checks++; if (dir_out !== DirInvert) begin n_fail++; $display("FAIL init_dir: got %0b expected %0b", dir_out, DirInvert); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy: got %0b expected 0", busy); end
    n_checks++; if (cur_step !== 0) begin n_fail++; $display("FAIL init_cur: got %0d expected 0", cur_step); end
    n_checks++; if (lag !== 0 || err_lag !== 1'b0) begin n_fail++; $display("FAIL init_lag: got %0d/%0b expected 0/0", lag, err_lag); end
    tick(2);
    reset = 0; model_pos = 0; model_target = 0; model_err = 0; mon_en = 1;
    tick(1);
  endtask

  task automatic test_forward();
    clear_hist();
    enable = 1;
    strobe(longint'(3) << 20);
    tick(1);
    n_checks++; if (dir_out !== 1'b1 || step_out !== 1'b0) begin n_fail++; $display("FAIL fwd_setup: dir/step %0b/%0b expected 1/0", dir_out, step_out); end
    tick(3);
    n_checks++; if (step_out !== 1'b0) begin n_fail++; $display("FAIL fwd_setup_end: step %0b expected 0", step_out); end
    tick(1);
    n_checks++; if (step_out !== 1'b1) begin n_fail++; $display("FAIL fwd_first_rise: step %0b expected 1", step_out); end
    tick(25);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fwd_busy_last_low: got %0b expected 1", busy); end
    tick(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fwd_busy_done: got %0b expected 0", busy); end
    n_checks++;
    if (setup_q.size() != 3 || fall_q.size() != 3) begin
      n_fail++; $display("FAIL fwd_pulses: got %0d rises expected 3", setup_q.size());
    end else begin
      n_checks++; if (setup_q[0] != 4) begin n_fail++; $display("FAIL fwd_setup_len: got %0d expected 4", setup_q[0]); end
      n_checks++; if (low_q[1] != 6 || low_q[2] != 6) begin n_fail++; $display("FAIL fwd_period: low %0d,%0d expected 6,6", low_q[1], low_q[2]); end
      n_checks++; if (fall_q[0] != 1 || fall_q[1] != 2 || fall_q[2] != 3) begin n_fail++; $display("FAIL fwd_falls: got %0d,%0d,%0d expected 1,2,3", fall_q[0], fall_q[1], fall_q[2]); end
    end
    n_checks++; if (cur_step !== 3) begin n_fail++; $display("FAIL fwd_cur: got %0d expected 3", cur_step); end
  endtask

  task automatic test_reverse();
    bit ok;
    clear_hist();
    strobe(longint'(1) << 20);
    tick(1);
    n_checks++; if (dir_out !== 1'b0) begin n_fail++; $display("FAIL rev_dir: got %0b expected 0", dir_out); end
    settle(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rev_timeout: busy %0b lag %0d expected idle", busy, lag); end
    n_checks++;
    if (setup_q.size() != 2 || fall_q.size() != 2) begin
      n_fail++; $display("FAIL rev_pulses: got %0d rises expected 2", setup_q.size());
    end else begin
      n_checks++; if (setup_q[0] != 4) begin n_fail++; $display("FAIL rev_setup_len: got %0d expected 4", setup_q[0]); end
      n_checks++; if (fall_q[0] != 2 || fall_q[1] != 1) begin n_fail++; $display("FAIL rev_falls: got %0d,%0d expected 2,1", fall_q[0], fall_q[1]); end
    end
  endtask

  task automatic test_rounding();
    bit ok;
    int r0;
    r0 = rise_cnt;
    strobe((longint'(1) << 20) + (longint'(1) << 19));
    tick(3);
    n_checks++; if (lag !== 0 || busy !== 1'b0 || rise_cnt != r0) begin n_fail++; $display("FAIL round_hold: lag %0d rises %0d expected 0 0", lag, rise_cnt - r0); end
    strobe(-1);
    n_checks++; if (step_out !== 1'b0 || lag !== -2) begin n_fail++; $display("FAIL round_e0: step %0b lag %0d expected 0 -2", step_out, lag); end
    tick(1);
    n_checks++; if (step_out !== 1'b1) begin n_fail++; $display("FAIL latency_e1: step %0b expected 1", step_out); end
    settle(100, ok);
    n_checks++; if (!ok || cur_step !== -1 || rise_cnt - r0 != 2) begin n_fail++; $display("FAIL round_neg: cur %0d rises %0d expected -1 2", cur_step, rise_cnt - r0); end
  endtask

  task automatic test_follow_err();
    bit ok;
    strobe(longint'(100) << 20);
    n_checks++; if (err_lag !== 1'b0) begin n_fail++; $display("FAIL ferr_e0: got %0b expected 0", err_lag); end
    tick(1);
    n_checks++; if (err_lag !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %0b expected 1", err_lag); end
    clear_err = 1; tick(1); clear_err = 0;
    n_checks++; if (err_lag !== 1'b1) begin n_fail++; $display("FAIL ferr_set_wins: got %0b expected 1", err_lag); end
    for (int i = 0; i < 2000 && (lag > 8 || lag < -8); i++) tick(1);
    n_checks++; if (lag > 8 || lag < -8) begin n_fail++; $display("FAIL ferr_catchup: lag %0d expected <= 8", lag); end
    clear_err = 1; tick(1); clear_err = 0;
    n_checks++; if (err_lag !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %0b expected 0", err_lag); end
    settle(200, ok);
    n_checks++; if (!ok || cur_step !== 100) begin n_fail++; $display("FAIL ferr_final: cur %0d expected 100", cur_step); end
  endtask

  task automatic test_preset();
    int r0;
    strobe(longint'(105) << 20);
    for (int i = 0; i < 20 && !step_out; i++) tick(1);
    n_checks++; if (step_out !== 1'b1) begin n_fail++; $display("FAIL preset_pulse: step %0b expected 1", step_out); end
    preset = 1; preset_x = 48'(longint'(50) << 20); in_valid = 1; in_x = 0;
    tick(1);
    preset = 0; in_valid = 0;
    n_checks++; if (step_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL preset_stop: step/busy %0b/%0b expected 0/0", step_out, busy); end
    n_checks++; if (cur_step !== 50 || lag !== 0) begin n_fail++; $display("FAIL preset_pos: cur %0d lag %0d expected 50 0", cur_step, lag); end
    r0 = rise_cnt;
    tick(30);
    n_checks++; if (rise_cnt != r0 || cur_step !== 50) begin n_fail++; $display("FAIL preset_quiet: rises %0d cur %0d expected 0 50", rise_cnt - r0, cur_step); end
  endtask

  task automatic test_enable();
    bit ok;
    int r0;
    enable = 0; r0 = rise_cnt;
    strobe(longint'(53) << 20);
    tick(20);
    n_checks++; if (rise_cnt != r0 || busy !== 1'b0 || lag !== 3) begin n_fail++; $display("FAIL en_hold: rises %0d lag %0d expected 0 3", rise_cnt - r0, lag); end
    enable = 1;
    for (int i = 0; i < 20 && !step_out; i++) tick(1);
    enable = 0;
    tick(15);
    n_checks++; if (cur_step !== 51 || busy !== 1'b0 || rise_cnt - r0 != 1) begin n_fail++; $display("FAIL en_drop: cur %0d rises %0d expected 51 1", cur_step, rise_cnt - r0); end
    enable = 1;
    settle(100, ok);
    n_checks++; if (!ok || cur_step !== 53) begin n_fail++; $display("FAIL en_resume: cur %0d expected 53", cur_step); end
  endtask

  task automatic test_random();
    bit ok;
    longint unit, x;
    unit = longint'(1) << 20;
    for (int it = 0; it < 40; it++) begin
      x = (model_target + longint'(int'($urandom_range(0, 24)) - 12)) * unit +
          longint'($urandom_range(0, 32'hf_ffff));
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        preset = 1; preset_x = 48'(x); tick(1); preset = 0;
      end else begin
        strobe(x);
      end
      repeat ($urandom_range(0, 40)) begin
        clear_err = ($urandom_range(0, 7) == 0);
        tick(1);
      end
      clear_err = 0;
    end
    enable = 1;
    settle(3000, ok);
    n_checks++; if (!ok || longint'(cur_step) != model_target) begin n_fail++; $display("FAIL rand_final: cur %0d expected %0d", cur_step, model_target); end
  endtask

  task automatic test_reset();
    strobe((model_target + 5) << 20);
    for (int i = 0; i < 30 && !step_out; i++) tick(1);
    n_checks++; if (step_out !== 1'b1) begin n_fail++; $display("FAIL rst_pulse: step %0b expected 1", step_out); end
    #2;
    mon_en = 0; reset = 1;
    #1;
    n_checks++; if (step_out !== 1'b0) begin n_fail++; $display("FAIL rst_async_step: got %0b expected 0", step_out); end
    n_checks++; if (dir_out !== DirInvert || busy !== 1'b0) begin n_fail++; $display("FAIL rst_dir_busy: %0b/%0b expected %0b/0", dir_out, busy, DirInvert); end
    n_checks++; if (cur_step !== 0 || lag !== 0 || err_lag !== 1'b0) begin n_fail++; $display("FAIL rst_state: cur %0d lag %0d err %0b expected 0", cur_step, lag, err_lag); end
    tick(2);
    reset = 0; model_pos = 0; model_target = 0; model_err = 0; mon_en = 1;
    tick(5);
  endtask

  initial begin
    test_reset_init();
    test_forward();
    test_reverse();
    test_rounding();
    test_follow_err();
    test_preset();
    test_enable();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
